adc_serial_emulator: RTL and testbench
======================================

Name: adc_serial_emulator

Overview:
- Synthesizable, parametrised model of an external serial-output SAR ADC for testbenches and on-board loopback.
- Responds to an active-low convert strobe, asserts busy, waits a conversion time, then shifts one DATA_W-bit sample per channel on parallel sdout lines with a generated serial clock.
- Adds per-channel data, selectable data sources, bit order, programmable timing and overrun reporting.

Parameters:
- DATA_W, 16, sample width in bits (2..32)
- CHANNELS, 2, number of parallel sdout lanes (1..8)
- CONV_CYCLES, 4, clk cycles between convert detection and first bit (>=1)
- SCLK_DIV, 2, sclk half-period in clk cycles (>=1)
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
- PATTERN, 16'hACCF, fixed test word, zero-extended/truncated to DATA_W

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- nconv  in  1  convert request, active-low, falling edge starts conversion
- data_mode  in  2  0 = fixed pattern, 1 = counter, 2 = loaded, 3 = same as 0
- load_en  in  1  load strobe for load_data
- load_data  in  CHANNELS*DATA_W  per-channel words, channel 0 in LSBs
- busy  out  1  high from conversion start until the last bit period ends
- sclk  out  1  serial clock; receiver samples sdout on rising edge
- sdout  out  CHANNELS  serial data, one lane per channel
- overrun  out  1  one-cycle pulse: falling edge of nconv while busy
- conv_count  out  16  completed conversions, wraps at 16'hFFFF -> 0

Behaviour:
- Reset: state IDLE; busy=0, sclk=0, sdout=0, overrun=0, conv_count=0, sample counter=0, load regs=0, nconv_q=1.
- Edge detect: start = nconv_q & ~nconv; nconv_q registered every cycle.
- States: IDLE, CONV, SHIFT, DONE.
- IDLE: on start -> CONV, busy=1 next cycle, per-channel sample words captured on the same edge.
- Sample for channel c: mode 0/3 = PATTERN ^ c; mode 1 = sample counter + c (mod 2^DATA_W); mode 2 = load register c. Sample counter increments by 1 per captured conversion, wraps.
- load_en: load registers updated from load_data on any cycle; a load coinciding with start is NOT visible to that conversion (old value captured).
- CONV: CONV_CYCLES cycles, busy=1, sclk=0, sdout=0, then -> SHIFT.
- SHIFT: DATA_W bit periods of 2*SCLK_DIV cycles each. At start of each period sclk=0 and sdout presents the next bit (MSB first if MSB_FIRST else LSB first); after SCLK_DIV cycles sclk=1 for SCLK_DIV cycles. After last period -> DONE.
- DONE: 1 cycle; busy=0, sclk=0, sdout=0, conv_count += 1; -> IDLE. A start in DONE is accepted next cycle only if the edge is seen in IDLE (edge in DONE is treated as overrun).
- Total busy length = CONV_CYCLES + DATA_W*2*SCLK_DIV cycles.
- start while in CONV/SHIFT/DONE: ignored, overrun=1 for one cycle, current transfer unaffected.
- nconv held low: only one conversion; new conversion requires a new falling edge.
- data_mode changes mid-transfer: no effect on the captured words.
- rst mid-transfer: immediate return to reset values on the next edge; no DONE, conv_count not incremented (cleared).

Test Plan:
- Defaults, mode 0, nconv falls at cycle 10 -> busy rises cycle 11, stays 68 cycles; lane0 shifts ACCF MSB first, lane1 ACCE; conv_count=1 after DONE.
- Mode 1, three conversions -> lane0 words 0000,0001,0002; lane1 0001,0002,0003; conv_count=3.
- Mode 2, load_data=32'h1234_5678 with load_en -> lane0 5678, lane1 1234; load issued in the start cycle with new value 32'hFFFF_FFFF -> previous words still sent.
- MSB_FIRST=0, DATA_W=8, SCLK_DIV=1, PATTERN=8'hA5 -> lane0 bits 1,0,1,0,0,1,0,1; each sclk high one cycle; busy length 4+16=20.
- Second nconv falling edge during SHIFT -> overrun one-cycle pulse, transfer bits unchanged, conv_count +1 only.
- rst asserted halfway through SHIFT -> next cycle busy=0, sclk=0, sdout=0, conv_count=0, state IDLE; next falling edge of nconv starts a clean transfer.

Source files
------------

// File: rtl/adc_serial_emulator_if.sv
// Bus bundle between an ADC emulator and whatever drives its convert strobe and reads its lanes.
// Latency: none, this is wiring only.
// Backpressure: none; the master owns nconv/data_mode/load_*, the slave owns busy/sclk/sdout/overrun/conv_count.
interface adc_serial_emulator_if #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2
);
    logic                         nconv;
    logic [1:0]                   data_mode;
    logic                         load_en;
    logic [CHANNELS*DATA_W-1:0]   load_data;
    logic                         busy;
    logic                         sclk;
    logic [CHANNELS-1:0]          sdout;
    logic                         overrun;
    logic [15:0]                  conv_count;

    modport master (
        output nconv, data_mode, load_en, load_data,
        input  busy, sclk, sdout, overrun, conv_count
    );

    modport slave (
        input  nconv, data_mode, load_en, load_data,
        output busy, sclk, sdout, overrun, conv_count
    );
endinterface

// File: rtl/adc_serial_emulator.sv
// Emulates a serial-output SAR ADC: a falling nconv edge captures one word per lane and shifts it out with sclk.
// Latency: busy rises 1 clk after the edge is sampled and stays high for CONV_CYCLES + DATA_W*2*SCLK_DIV clks.
// Backpressure: none; a new edge while a transfer is running is dropped and flagged with a one-cycle overrun.
//
// Ports: clk, rst (sync, active-high); bus (slave modport): nconv, data_mode, load_en, load_data in;
//        busy, sclk, sdout[CHANNELS], overrun, conv_count out. All outputs are registered.
module adc_serial_emulator #(
    parameter int          DATA_W      = 16,
    parameter int          CHANNELS    = 2,
    parameter int          CONV_CYCLES = 4,
    parameter int          SCLK_DIV    = 2,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter logic [31:0] PATTERN     = 32'h0000_ACCF
) (
    input logic                  clk,
    input logic                  rst,
    adc_serial_emulator_if.slave bus
);

    // One counter serves both the conversion wait and the position inside a bit period.
    localparam int CNT_MAX = (CONV_CYCLES > 2 * SCLK_DIV) ? CONV_CYCLES : 2 * SCLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BIT_W   = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t             state;
    logic               nconv_q;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  samp_cnt;
    logic [DATA_W-1:0]  load_reg [CHANNELS];
    logic [DATA_W-1:0]  shreg    [CHANNELS];

    logic               start;
    logic [DATA_W-1:0]  word     [CHANNELS];
    logic [DATA_W-1:0]  shifted  [CHANNELS];
    logic [CHANNELS-1:0] out_bit;

    assign start = nconv_q & ~bus.nconv;

    // Words offered for capture. load_reg is read before this cycle's load lands,
    // so a load in the start cycle is only seen by the next conversion.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            word[c] = PATTERN[DATA_W-1:0] ^ DATA_W'(c);
            case (bus.data_mode)
                2'd1:    word[c] = samp_cnt + DATA_W'(c);
                2'd2:    word[c] = load_reg[c];
                default: word[c] = PATTERN[DATA_W-1:0] ^ DATA_W'(c);
            endcase
        end
    end

    // Next bit to present and the register after it has been consumed.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            out_bit[c] = MSB_FIRST ? shreg[c][DATA_W-1] : shreg[c][0];
            shifted[c] = MSB_FIRST ? (shreg[c] << 1) : (shreg[c] >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            nconv_q        <= 1'b1;
            cyc_cnt        <= '0;
            bit_cnt        <= '0;
            samp_cnt       <= '0;
            bus.busy       <= 1'b0;
            bus.sclk       <= 1'b0;
            bus.sdout      <= '0;
            bus.overrun    <= 1'b0;
            bus.conv_count <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                load_reg[c] <= '0;
                shreg[c]    <= '0;
            end
        end else begin
            nconv_q     <= bus.nconv;
            // Any edge outside IDLE (DONE included) is dropped and reported.
            bus.overrun <= start && (state != IDLE);

            if (bus.load_en) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    load_reg[c] <= bus.load_data[c*DATA_W +: DATA_W];
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CONV;
                        bus.busy <= 1'b1;
                        cyc_cnt  <= '0;
                        samp_cnt <= samp_cnt + DATA_W'(1);
                        shreg    <= word;
                    end
                end
                CONV: begin
                    if (cyc_cnt == CONV_LAST) begin
                        // First bit period opens with sclk low and bit 0 already on the lanes.
                        state     <= SHIFT;
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                        bus.sclk  <= 1'b0;
                        bus.sdout <= out_bit;
                        shreg     <= shifted;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cyc_cnt == PER_LAST) begin
                        cyc_cnt  <= '0;
                        bus.sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state          <= DONE;
                            bus.busy       <= 1'b0;
                            bus.sdout      <= '0;
                            bus.conv_count <= bus.conv_count + 16'd1;
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            bus.sdout <= out_bit;
                            shreg     <= shifted;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                        // Second half of the period: rising sclk, data already stable.
                        if (cyc_cnt == HALF_LAST) begin
                            bus.sclk <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_emulator.sv
module tb_adc_serial_emulator;

    localparam int DW    = 16;
    localparam int CONV  = 4;
    localparam int DIV   = 2;
    // Cycles from the first busy cycle through the DONE cycle.
    localparam int TOT   = CONV + DW * 2 * DIV + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_serial_emulator_if #(.DATA_W(16), .CHANNELS(2)) ifc ();
    adc_serial_emulator_if #(.DATA_W(8),  .CHANNELS(2)) ifc8 ();

    adc_serial_emulator #(
        .DATA_W(16), .CHANNELS(2), .CONV_CYCLES(4), .SCLK_DIV(2),
        .MSB_FIRST(1'b1), .PATTERN(32'h0000_ACCF)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(ifc)
    );

    adc_serial_emulator #(
        .DATA_W(8), .CHANNELS(2), .CONV_CYCLES(4), .SCLK_DIV(1),
        .MSB_FIRST(1'b0), .PATTERN(32'h0000_00A5)
    ) u_dut8 (
        .clk(clk), .rst(rst), .bus(ifc8)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (default instance) ----------------
    // Tracks only "cycles since the accepted edge"; every output follows from that offset.
    bit          m_act;
    int          m_k;
    logic [15:0] m_words [2];
    logic [15:0] m_load  [2];
    logic [15:0] m_samp;
    logic [15:0] m_cc;
    logic        m_nq;
    logic        m_ovr;
    bit          m_st;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_k = 0; m_samp = 0; m_cc = 0; m_nq = 1'b1; m_ovr = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_load[c]  = '0;
                m_words[c] = '0;
            end
        end else begin
            m_st  = m_nq && !ifc.nconv;
            m_ovr = m_st && m_act;
            if (m_act) begin
                m_k++;
                if (m_k == TOT) m_cc++;
                if (m_k > TOT) m_act = 0;
            end else if (m_st) begin
                for (int c = 0; c < 2; c++) begin
                    case (ifc.data_mode)
                        2'd1:    m_words[c] = m_samp + 16'(c);
                        2'd2:    m_words[c] = m_load[c];
                        default: m_words[c] = 16'hACCF ^ 16'(c);
                    endcase
                end
                m_samp++;
                m_act = 1;
                m_k   = 1;
            end
            if (ifc.load_en) begin
                for (int c = 0; c < 2; c++) m_load[c] = ifc.load_data[c*16 +: 16];
            end
            m_nq = ifc.nconv;
        end
    end

    logic       e_busy, e_sclk;
    logic [1:0] e_sd;
    int         e_j, e_b;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = 1'b0; e_sclk = 1'b0; e_sd = 2'b00;
            if (m_act && m_k <= TOT - 1) begin
                e_busy = 1'b1;
                if (m_k > CONV) begin
                    e_j    = m_k - CONV - 1;
                    e_b    = e_j / (2 * DIV);
                    e_sclk = (e_j % (2 * DIV)) >= DIV;
                    for (int c = 0; c < 2; c++) e_sd[c] = m_words[c][DW-1-e_b];
                end
            end
            check("cyc_busy",       32'(ifc.busy),       32'(e_busy));
            check("cyc_sclk",       32'(ifc.sclk),       32'(e_sclk));
            check("cyc_sdout",      32'(ifc.sdout),      32'(e_sd));
            check("cyc_overrun",    32'(ifc.overrun),    32'(m_ovr));
            check("cyc_conv_count", 32'(ifc.conv_count), 32'(m_cc));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulls nconv low and collects one transfer. poke_kind: 1 = second nconv edge,
    // 2 = switch data_mode to counter, 3 = drop load_en.
    task automatic xfer(input int poke_at, input int poke_kind,
                        output logic [15:0] w0, output logic [15:0] w1,
                        output int blen, output int novr);
        logic ps;
        bit   seen, done;
        w0 = '0; w1 = '0; blen = 0; novr = 0; ps = 1'b0; seen = 0; done = 0;
        ifc.nconv = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (ifc.overrun) novr++;
            if (ifc.busy) begin
                blen++;
                seen = 1;
            end else if (seen) begin
                done = 1;
            end
            if (ifc.sclk && !ps) begin
                w0 = {w0[14:0], ifc.sdout[0]};
                w1 = {w1[14:0], ifc.sdout[1]};
            end
            ps = ifc.sclk;
            if (i == poke_at) begin
                case (poke_kind)
                    1: ifc.nconv     = 1'b1;
                    2: ifc.data_mode = 2'd1;
                    3: ifc.load_en   = 1'b0;
                    default: ;
                endcase
            end
            if (poke_kind == 1 && i == poke_at + 1) ifc.nconv = 1'b0;
        end
        check("xfer_completed", 32'(done), 32'd1);
    endtask

    logic [15:0] w0, w1;
    int          bl, no;
    logic [7:0]  seq0, seq1;
    int          nbits, hi_cnt, bl8;
    logic        ps8;
    bit          seen8, done8;

    initial begin
        ifc.nconv = 1'b1; ifc.data_mode = 2'd0; ifc.load_en = 1'b0; ifc.load_data = '0;
        ifc8.nconv = 1'b1; ifc8.data_mode = 2'd0; ifc8.load_en = 1'b0; ifc8.load_data = '0;
        rst = 1'b1;
        tick(3);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy",       32'(ifc.busy),        32'd0);
        check("rst_sdout",      32'(ifc.sdout),       32'd0);
        check("rst_conv_count", 32'(ifc.conv_count),  32'd0);
        check("rst8_busy",      32'(ifc8.busy),       32'd0);
        tick(1);
        rst = 1'b0;

        // Pattern mode, data_mode flipped mid-transfer must not matter.
        tick(5);
        xfer(30, 2, w0, w1, bl, no);
        check("t1_lane0", 32'(w0), 32'h0000_ACCF);
        check("t1_lane1", 32'(w1), 32'h0000_ACCE);
        check("t1_busy_len", 32'(bl), 32'd68);
        check("t1_conv_count", 32'(ifc.conv_count), 32'd1);
        // nconv held low: no second conversion.
        tick(10);
        check("t1_held_low_busy", 32'(ifc.busy), 32'd0);
        check("t1_held_low_count", 32'(ifc.conv_count), 32'd1);
        ifc.nconv = 1'b1;
        ifc.data_mode = 2'd0;

        // LSB-first 8-bit instance, sclk high exactly one cycle per bit.
        tick(3);
        ifc8.nconv = 1'b0;
        seq0 = '0; seq1 = '0; nbits = 0; hi_cnt = 0; bl8 = 0; ps8 = 1'b0; seen8 = 0; done8 = 0;
        for (int i = 0; i < 200 && !done8; i++) begin
            @(negedge clk);
            if (ifc8.busy) begin
                bl8++;
                seen8 = 1;
            end else if (seen8) begin
                done8 = 1;
            end
            if (ifc8.sclk) hi_cnt++;
            if (ifc8.sclk && !ps8 && nbits < 8) begin
                seq0[nbits] = ifc8.sdout[0];
                seq1[nbits] = ifc8.sdout[1];
                nbits++;
            end
            ps8 = ifc8.sclk;
        end
        check("t4_completed", 32'(done8), 32'd1);
        check("t4_lane0_bits", 32'(seq0), 32'h0000_00A5);
        check("t4_lane1_bits", 32'(seq1), 32'h0000_00A4);
        check("t4_nbits", 32'(nbits), 32'd8);
        check("t4_sclk_high_cycles", 32'(hi_cnt), 32'd8);
        check("t4_busy_len", 32'(bl8), 32'd20);
        check("t4_conv_count", 32'(ifc8.conv_count), 32'd1);
        ifc8.nconv = 1'b1;

        // Counter mode from a fresh reset.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ifc.data_mode = 2'd1;
        for (int n = 0; n < 3; n++) begin
            tick(3);
            xfer(-1, 0, w0, w1, bl, no);
            check("t2_lane0", 32'(w0), 32'(n));
            check("t2_lane1", 32'(w1), 32'(n + 1));
            ifc.nconv = 1'b1;
        end
        check("t2_conv_count", 32'(ifc.conv_count), 32'd3);

        // Loaded words; a load in the start cycle is not seen by that conversion.
        ifc.data_mode = 2'd2;
        ifc.load_data = 32'h1234_5678;
        ifc.load_en   = 1'b1;
        tick(1);
        ifc.load_en   = 1'b0;
        tick(2);
        xfer(-1, 0, w0, w1, bl, no);
        check("t3_lane0", 32'(w0), 32'h0000_5678);
        check("t3_lane1", 32'(w1), 32'h0000_1234);
        ifc.nconv = 1'b1;
        tick(3);
        ifc.load_data = 32'hFFFF_FFFF;
        ifc.load_en   = 1'b1;
        xfer(1, 3, w0, w1, bl, no);
        check("t3_start_load_lane0", 32'(w0), 32'h0000_5678);
        check("t3_start_load_lane1", 32'(w1), 32'h0000_1234);
        ifc.nconv = 1'b1;
        tick(3);
        xfer(-1, 0, w0, w1, bl, no);
        check("t3_after_load_lane0", 32'(w0), 32'h0000_FFFF);
        check("t3_after_load_lane1", 32'(w1), 32'h0000_FFFF);
        ifc.nconv = 1'b1;

        // Second edge during SHIFT: one overrun pulse, transfer untouched.
        ifc.data_mode = 2'd0;
        tick(3);
        xfer(30, 1, w0, w1, bl, no);
        check("t5_lane0", 32'(w0), 32'h0000_ACCF);
        check("t5_lane1", 32'(w1), 32'h0000_ACCE);
        check("t5_overrun_pulses", 32'(no), 32'd1);
        check("t5_busy_len", 32'(bl), 32'd68);
        check("t5_conv_count", 32'(ifc.conv_count), 32'd7);
        ifc.nconv = 1'b1;

        // Reset halfway through SHIFT, then a clean transfer.
        tick(3);
        ifc.nconv = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        tick(1);
        check("t6_rst_busy",  32'(ifc.busy),       32'd0);
        check("t6_rst_sclk",  32'(ifc.sclk),       32'd0);
        check("t6_rst_sdout", 32'(ifc.sdout),      32'd0);
        check("t6_rst_count", 32'(ifc.conv_count), 32'd0);
        rst = 1'b0;
        ifc.nconv = 1'b1;
        tick(3);
        xfer(-1, 0, w0, w1, bl, no);
        check("t6_lane0", 32'(w0), 32'h0000_ACCF);
        check("t6_lane1", 32'(w1), 32'h0000_ACCE);
        check("t6_busy_len", 32'(bl), 32'd68);
        check("t6_conv_count", 32'(ifc.conv_count), 32'd1);
        ifc.nconv = 1'b1;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
